// File: rtl/button_debounce.sv
// button_debounce: pad synchroniser plus counter-qualified debounce FSM emitting a clean level and
// press/release strobes. Long-press detection is built only when BUTTON_DEBOUNCE_LONG_PRESS_EN is defined.
//
// state        | meaning
// IDLE         | released and stable, waiting for sync=1
// PRESS_WAIT   | sync went high, counting consecutive high samples
// PRESSED      | press accepted, button_level=1
// RELEASE_WAIT | sync went low, counting consecutive low samples (level still 1)
module button_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int LONG_CYCLES     = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  output logic button_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 2 ||
      LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
    $error("button_debounce: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [DB_W-1:0]        db_cnt, db_cnt_nxt;
  logic                   level_nxt, press_nxt, release_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], button_raw};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      db_cnt        <= '0;
      button_level  <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      db_cnt        <= db_cnt_nxt;
      button_level  <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    db_cnt_nxt  = db_cnt;
    level_nxt   = button_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (sync) begin
          state_nxt  = PRESS_WAIT;
          db_cnt_nxt = DB_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_nxt  = IDLE;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          state_nxt  = PRESSED;
          db_cnt_nxt = '0;
          level_nxt  = 1'b1;
          press_nxt  = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_nxt  = RELEASE_WAIT;
          db_cnt_nxt = DB_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (sync) begin
          state_nxt  = PRESSED;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          state_nxt   = IDLE;
          db_cnt_nxt  = '0;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      default: begin
        state_nxt  = IDLE;
        db_cnt_nxt = '0;
        level_nxt  = 1'b0;
      end
    endcase
  end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              long_q;

  // Saturating at LONG_CYCLES is what limits the strobe to once per press.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      long_q   <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (press_nxt) begin
        hold_cnt <= '0;
      end else if (button_level && hold_cnt != HOLD_W'(LONG_CYCLES)) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
        if (hold_cnt == HOLD_W'(LONG_CYCLES - 1)) long_q <= 1'b1;
      end
    end
  end

  assign long_press_pulse = long_q;
`else
  assign long_press_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Testbench for button_debounce: directed vector table, hand-written corner sequences and
// random bursts checked against a run-length reference model.
module tb_button_debounce;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int LONG = 20;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, button_raw;
  logic button_level, press_pulse, release_pulse, long_press_pulse;

  button_debounce #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LONG)
  ) dut (
    .clk(clk), .rst(rst), .button_raw(button_raw),
    .button_level(button_level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .long_press_pulse(long_press_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         raw;
    bit         rs;
    logic [3:0] exp;   // {level, press, release, long}
  } vec_t;
  vec_t vecs[$];

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int press_cnt, rel_cnt, long_cnt;
  int last_press, last_rel, last_long;
  logic [3:0] got, mexp;

  // Reference model: raw samples reach the filter after SYNC edges (a reset flushes them);
  // the level flips once DB consecutive samples disagree with it.
  bit dq[$];
  bit m_level, run_val;
  int run, held;
  bit m_press, m_rel, m_long;

  task automatic model_edge(input bit r, input bit rs);
    bit s, prev;
    m_press = 0; m_rel = 0; m_long = 0;
    if (rs) begin
      dq.delete();
      repeat (SYNC) dq.push_back(1'b0);
      m_level = 0; run_val = 0; run = 0; held = 0;
      return;
    end
    s = dq.pop_front();
    dq.push_back(r);
    prev = m_level;
    if (s == run_val) run++;
    else begin
      run_val = s;
      run = 1;
    end
    if (run_val != m_level && run >= DB) begin
      m_level = run_val;
      if (m_level) m_press = 1;
      else         m_rel = 1;
    end
    if (prev && held < LONG) begin
      held++;
      if (held == LONG) m_long = LONG_EN;
    end
    if (m_press) held = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc_n, act, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit rs);
    button_raw = r;
    rst = rs;
    @(posedge clk);
    model_edge(r, rs);
    @(negedge clk);
    cyc_n++;
    got  = {button_level, press_pulse, release_pulse, long_press_pulse};
    mexp = {m_level, m_press, m_rel, m_long};
    if (press_pulse)      begin press_cnt++; last_press = cyc_n; end
    if (release_pulse)    begin rel_cnt++;   last_rel   = cyc_n; end
    if (long_press_pulse) begin long_cnt++;  last_long  = cyc_n; end
  endtask

  task automatic cyc_m(input bit r, input bit rs);
    cyc(r, rs);
    chk("model", 32'(got), 32'(mexp));
  endtask

  task automatic clr_cnt();
    press_cnt = 0; rel_cnt = 0; long_cnt = 0;
    last_press = -1; last_rel = -1; last_long = -1;
  endtask

  function automatic void add(input bit r, input bit rs, input logic [3:0] e, input int n);
    vec_t v;
    v.raw = r; v.rs = rs; v.exp = e;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  initial begin
    int start, lo, val, len;
    rst = 1'b1;
    button_raw = 1'b0;
    repeat (SYNC) dq.push_back(1'b0);
    clr_cnt();

    // reset, idle, clean press (pulse at edge 6), clean release (pulse at edge 6)
    add(0, 1, 4'b0000, 3);
    add(0, 0, 4'b0000, 10);
    add(1, 0, 4'b0000, 5);
    add(1, 0, 4'b1100, 1);
    add(1, 0, 4'b1000, 2);
    add(0, 0, 4'b1000, 5);
    add(0, 0, 4'b0010, 1);
    add(0, 0, 4'b0000, 2);
    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].raw, vecs[i].rs);
      chk("vec", 32'(got), 32'(vecs[i].exp));
    end

    // bounce rejection
    clr_cnt();
    foreach (vecs[i]) ;
    for (int i = 0; i < 8; i++) cyc_m(((i / 2) % 2) == 0, 0);
    chk("bounce_no_pulse", press_cnt + rel_cnt, 0);
    start = cyc_n;
    for (int i = 0; i < 10; i++) cyc_m(1, 0);
    chk("bounce_press_cnt", press_cnt, 1);
    chk("bounce_press_lat", last_press - start, 6);

    // long press held for 100 more cycles, then release
    for (int i = 0; i < 100; i++) cyc_m(1, 0);
    lo = (long_cnt > 0) ? last_long - last_press : -1;
    chk("long_cnt", long_cnt, LONG_EN ? 1 : 0);
    chk("long_ofs", lo, LONG_EN ? 20 : -1);
    start = cyc_n;
    for (int i = 0; i < 10; i++) cyc_m(0, 0);
    chk("long_rel_cnt", rel_cnt, 1);
    chk("long_rel_lat", last_rel - start, 6);
    chk("long_rel_level", 32'(button_level), 0);

    // short press
    clr_cnt();
    for (int i = 0; i < 10; i++) cyc_m(1, 0);
    for (int i = 0; i < 12; i++) cyc_m(0, 0);
    chk("short_press_cnt", press_cnt, 1);
    chk("short_rel_cnt", rel_cnt, 1);
    chk("short_long_cnt", long_cnt, 0);

    // reset while pressed, button still held afterwards
    clr_cnt();
    for (int i = 0; i < 8; i++) cyc_m(1, 0);
    chk("pre_rst_level", 32'(button_level), 1);
    cyc(1, 1);
    chk("rst_mid_out", 32'(got), 0);
    clr_cnt();
    start = cyc_n;
    for (int i = 0; i < 10; i++) cyc_m(1, 0);
    chk("rst_repress_cnt", press_cnt, 1);
    chk("rst_repress_lat", last_press - start, 6);
    for (int i = 0; i < 10; i++) cyc_m(0, 0);

    // random bursts including occasional long holds and resets
    for (int k = 0; k < 300; k++) begin
      val = $urandom_range(0, 1);
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 7);
      for (int i = 0; i < len; i++) cyc_m(val[0], 0);
      if ($urandom_range(0, 39) == 0) cyc_m(val[0], 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Front-end conditioning stage for one mechanical push button.
- Synchronises the raw pad into the clk domain and filters contact bounce with a counter-qualified state machine.
- Emits a clean level plus single-cycle press, release and long-press strobes.
- The LED control logic consumes press_pulse directly for toggle operations; it needs no edge detector of its own.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on button_raw; legal range 2..4.
- DEBOUNCE_CYCLES, 500_000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); minimum 2.
- LONG_CYCLES, 50_000_000, debounced-pressed cycles before long_press_pulse fires (1 s at 50 MHz); must be greater than DEBOUNCE_CYCLES.

Ports:
- clk  input  1  50 MHz system clock; every flop is clocked on its rising edge.
- rst  input  1  synchronous, active-high reset.
- button_raw  input  1  asynchronous, bouncy pad level; 1 = pressed.
- button_level  output  1  debounced level; 1 = pressed.
- press_pulse  output  1  one-cycle strobe on accepted press.
- release_pulse  output  1  one-cycle strobe on accepted release.
- long_press_pulse  output  1  one-cycle strobe, at most once per press.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Synchroniser flops, debounce counter and hold counter are cleared to 0.
  - State goes to IDLE.
  - All outputs are driven 0.
  - Reset overrides every other event in the same cycle.
- Synchroniser: button_raw passes through a SYNC_STAGES-deep flop chain. The final stage, sync, is the only value the FSM uses.
- FSM states:
  - IDLE, button_level=0:
    - sync=1 -> PRESS_WAIT, with the debounce counter set to 1.
  - PRESS_WAIT:
    - sync=0 -> IDLE, counter cleared (bounce rejected, no pulse).
    - sync=1 with counter == DEBOUNCE_CYCLES-1 -> PRESSED; button_level<=1, press_pulse<=1, hold counter cleared.
    - Otherwise the counter increments.
  - PRESSED, button_level=1:
    - sync=0 -> RELEASE_WAIT, with the debounce counter set to 1.
  - RELEASE_WAIT, button_level stays 1:
    - sync=1 -> PRESSED (bounce rejected).
    - sync=0 with counter == DEBOUNCE_CYCLES-1 -> IDLE; button_level<=0, release_pulse<=1.
    - Otherwise the counter increments.
- Latency:
  - Number edges from edge 1, the first edge that samples a new stable raw value.
  - press_pulse and release_pulse rise at edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - Each pulse is exactly one cycle wide.
- Hold counter:
  - Increments on every cycle that button_level=1, in both PRESSED and RELEASE_WAIT.
  - Saturates at LONG_CYCLES.
  - long_press_pulse is registered high on the edge the count reaches LONG_CYCLES, i.e. LONG_CYCLES edges after the press_pulse edge. It never repeats within the same press.
  - The counter clears on the press_pulse edge.
- Pulse exclusivity:
  - press_pulse and release_pulse are never high together.
  - long_press_pulse may coincide with the first cycle of RELEASE_WAIT.
  - long_press_pulse is never issued after release_pulse for the same press.
- Widths: counters are sized with $clog2 of their terminal values. There is no wrap-around: the debounce counter is bounded by the FSM and the hold counter saturates.
- Reset mid-press: all outputs drop to 0 immediately. If the button is still held when rst deasserts, a fresh press_pulse follows after the normal latency.
- A raw glitch shorter than DEBOUNCE_CYCLES at any time changes no output.

Optional Feature:
- Macro: BUTTON_DEBOUNCE_LONG_PRESS_EN.
- Defined: the hold counter and long_press_pulse behave as described above.
- Undefined:
  - The hold counter is not instantiated.
  - long_press_pulse is tied to constant 0.
  - All other behaviour and latencies are unchanged.

Test Plan:
- Setup: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20; assert rst for 3 cycles. Expected: all outputs 0; they remain 0 with button_raw=0 for 10 cycles.
- Clean press: raw 0->1 and held. Expected: press_pulse high exactly at edge 6, for one cycle; button_level=1 from edge 6.
- Bounce rejection: raw toggles 1,0,1,0 with 2-cycle runs, then steady 1. Expected: no pulse during bouncing; a single press_pulse 6 edges after the steady 1 begins.
- Long press: hold raw=1. Expected: long_press_pulse one cycle, 20 edges after the press_pulse edge, not repeated over 100 cycles. Then release: release_pulse 6 edges after raw falls, button_level=0.
- Short press: raw=1 for 10 cycles, then 0. Expected: press_pulse, then release_pulse, no long_press_pulse. With BUTTON_DEBOUNCE_LONG_PRESS_EN undefined, long_press_pulse stays 0 in the long-press test.
- Reset mid-press: assert rst 1 cycle while button_level=1. Expected: outputs 0 at the following edge. With raw still 1, press_pulse recurs 6 edges after rst deasserts.
